mux2_x2: RTL and testbench
==========================

// Module: mux2_x2
// PURPOSE
// - 2:1 multiplexer cell (X2 drive-strength variant) for the datapath/standard-cell wrapper layer.
// - Combinational output Z = S ? B : A.
// - Also provides a registered copy Z_q for timing-closed consumers, so the cell drops in wherever a
//   flopped mux output is needed.
// PARAMETERS
// - WIDTH      1   bit width of A, B, Z, Z_q; S is always 1 bit shared by all lanes
// - RST_VAL    0   value loaded into Z_q on reset, WIDTH bits
// PORTS
// - clk    in   1      single clock; all sequential logic on rising edge
// - rst    in   1      reset, asynchronous, active-high
// - A      in   WIDTH  data input 0, selected when S=0
// - B      in   WIDTH  data input 1, selected when S=1
// - S      in   1      select
// - en     in   1      register-enable for Z_q; when 0, Z_q holds
// - Z      out  WIDTH  combinational mux output
// - Z_q    out  WIDTH  registered mux output
// - Z_vld  out  1      high once Z_q holds a captured value since the last reset
// BEHAVIOUR
// - Z = (S==1) ? B : A, bitwise per lane.
//   - Purely combinational, zero latency, independent of clk, rst and en.
//   - Z is never reset and is valid whenever its inputs are driven.
// - Truth table, WIDTH=1, listed as A B S : Z:
//   - 000:0  001:0  010:0  011:1  100:1  101:0  110:1  111:1
// - Z_q and Z_vld:
//   - rst=1 (asynchronous assertion): immediately Z_q=RST_VAL, Z_vld=0.
//   - rst=1 dominates en at every edge.
//   - Rising clk with rst=0 and en=1: Z_q <= Z as sampled at that edge (1-cycle latency); Z_vld <= 1.
//   - Rising clk with rst=0 and en=0: Z_q and Z_vld hold.
//   - Once set, Z_vld stays 1 until the next rst.
// - Deassertion of rst is taken synchronously to clk by the integrating block.
//   - The first capture occurs on the first rising edge with rst=0 and en=1.
// - Reset mid-operation: Z_q returns to RST_VAL at once; Z keeps following A, B, S.
// - Simultaneous change of S and data before an edge: Z_q captures the settled mux of the sampled values.
// - Simulation with S=X or Z:
//   - Lanes where A==B output A.
//   - All other lanes output X; do not silently pick A.
// STRUCTURE
// - Package mux2_pkg holds MUX2_DEF_WIDTH=1 and the typedef mux2_sel_e {SEL_A=0, SEL_B=1}.
// - One sub-module, mux2_core: a combinational WIDTH-bit 2:1 mux including the X-handling rule.
// - mux2_x2 instantiates mux2_core and adds the Z_q/Z_vld register stage.
// TESTING
// - Exhaustive WIDTH=1 sweep of A,B,S over 000..111 -> Z matches the truth table above:
//   011->1, 101->0, 100->1, 110->1.
// - rst=1, then A=1,B=0,S=0,en=1 with 1 clk after rst release -> Z_q=1, Z_vld=1.
//   - Then S=1 -> Z=0 immediately; Z_q=0 after the next edge.
// - en=0 with inputs toggling for 4 clks -> Z_q and Z_vld hold their previous values while Z tracks.
// - Assert rst between clock edges while Z_q=1 -> Z_q=0 and Z_vld=0 immediately.
//   - Z is unaffected throughout.
// - WIDTH=8, A=8'hA5, B=8'h3C:
//   - S=0 -> Z=8'hA5; S=1 -> Z=8'h3C.
//   - Registered copy matches one cycle later.
// - S=X with A=B=8'hFF -> Z=8'hFF; S=X with A=8'h00, B=8'hFF -> Z all X.

Source files
------------

// File: rtl/mux2_pkg.sv
// Shared types and defaults for the mux2 cell family.
// Imported by the core mux and the registered wrapper.
package mux2_pkg;

  localparam int MUX2_DEF_WIDTH = 1;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } mux2_sel_e;

endpackage

// File: rtl/mux2_core.sv
// Combinational WIDTH-bit 2:1 mux.
// An unknown select resolves per lane: agreeing inputs pass, others go X.
module mux2_core
  import mux2_pkg::*;
#(
  parameter int WIDTH = MUX2_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] Z
);

  // The conditional operator merges both arms bitwise when S is X/Z.
  assign Z = (S == SEL_B) ? B : A;

endmodule

// File: rtl/mux2_x2.sv
// 2:1 mux cell, X2 drive variant.
// Combinational output plus an enabled, async-reset registered copy.
module mux2_x2
  import mux2_pkg::*;
#(
  parameter int               WIDTH   = MUX2_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             en,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_q,
  output logic             Z_vld
);

  mux2_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .A(A),
    .B(B),
    .S(S),
    .Z(Z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z_q   <= RST_VAL;
      Z_vld <= 1'b0;
    end else if (en) begin
      Z_q   <= Z;
      Z_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux2_x2.sv
// Self-checking bench for mux2_x2 at WIDTH=1 and WIDTH=8.
// Expected values come from a truth table and a mask-based mux model.
module tb_mux2_x2;

  logic       clk;
  logic       rst1, rst8;
  logic [0:0] A1, B1, Z1, Zq1;
  logic       S1, en1, vld1;
  logic [7:0] A8, B8, Z8, Zq8;
  logic       S8, en8, vld8;

  int checks;
  int errors;

  logic [7:0] exp8_q;
  logic       exp8_vld;

  mux2_x2 #(
    .WIDTH(1),
    .RST_VAL(1'b0)
  ) dut1 (
    .clk(clk),
    .rst(rst1),
    .A(A1),
    .B(B1),
    .S(S1),
    .en(en1),
    .Z(Z1),
    .Z_q(Zq1),
    .Z_vld(vld1)
  );

  mux2_x2 #(
    .WIDTH(8),
    .RST_VAL(8'h5A)
  ) dut8 (
    .clk(clk),
    .rst(rst8),
    .A(A8),
    .B(B8),
    .S(S8),
    .en(en8),
    .Z(Z8),
    .Z_q(Zq8),
    .Z_vld(vld8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mux(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic s);
    logic [7:0] m;
    m = s ? 8'hFF : 8'h00;
    return (a & ~m) | (b & m);
  endfunction

  task automatic test_reset();
    rst1 = 1'b1;
    rst8 = 1'b1;
    #1;
    checks++;
    if (Zq1 !== 1'b0 || vld1 !== 1'b0) begin
      errors++;
      $display("FAIL reset1 got q=%b v=%b want q=0 v=0", Zq1, vld1);
    end
    checks++;
    if (Zq8 !== 8'h5A || vld8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8 got q=%h v=%b want q=5a v=0", Zq8, vld8);
    end
    @(negedge clk);
    rst1 = 1'b0;
    rst8 = 1'b0;
    exp8_q   = 8'h5A;
    exp8_vld = 1'b0;
  endtask

  task automatic test_truth();
    logic [7:0] tt;
    logic [2:0] v;
    tt = 8'b1101_1000;
    en1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {A1[0], B1[0], S1} = v;
      #1;
      checks++;
      if (Z1[0] !== tt[i]) begin
        errors++;
        $display("FAIL truth ABS=%b got %b want %b", v, Z1, tt[i]);
      end
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    @(negedge clk);
    rst1 = 1'b0;
    A1 = 1'b1; B1 = 1'b0; S1 = 1'b0; en1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Zq1 !== 1'b1 || vld1 !== 1'b1) begin
      errors++;
      $display("FAIL capture got q=%b v=%b want q=1 v=1", Zq1, vld1);
    end
    @(negedge clk);
    S1 = 1'b1;
    #1;
    checks++;
    if (Z1 !== 1'b0 || Zq1 !== 1'b1) begin
      errors++;
      $display("FAIL sel_flip got z=%b q=%b want z=0 q=1", Z1, Zq1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Zq1 !== 1'b0) begin
      errors++;
      $display("FAIL sel_flip_q got %b want 0", Zq1);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    A1 = 1'b1; S1 = 1'b0; en1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A1 = 1'($urandom);
      B1 = 1'($urandom);
      S1 = 1'($urandom);
      #1;
      checks++;
      if (Z1[0] !== ref_mux({7'd0, A1}, {7'd0, B1}, S1) >> 0 & 1'b1) begin
        errors++;
        $display("FAIL hold_z got %b A=%b B=%b S=%b", Z1, A1, B1, S1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Zq1 !== 1'b1 || vld1 !== 1'b1) begin
        errors++;
        $display("FAIL hold_q got q=%b v=%b want q=1 v=1", Zq1, vld1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    A1 = 1'b1; B1 = 1'b0; S1 = 1'b0;
    #2;
    rst1 = 1'b1;
    #1;
    checks++;
    if (Zq1 !== 1'b0 || vld1 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got q=%b v=%b want q=0 v=0", Zq1, vld1);
    end
    checks++;
    if (Z1 !== 1'b1) begin
      errors++;
      $display("FAIL async_rst_z got %b want 1", Z1);
    end
    S1 = 1'b1;
    B1 = 1'b1;
    en1 = 1'b1;
    #1;
    e = ref_mux(8'h01, 8'h01, 1'b1);
    checks++;
    if (Z1 !== e[0:0]) begin
      errors++;
      $display("FAIL rst_z_track got %b want %b", Z1, e[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Zq1 !== 1'b0 || vld1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_dominates got q=%b v=%b want q=0 v=0", Zq1, vld1);
    end
    @(negedge clk);
    rst1 = 1'b0;
    en1 = 1'b0;
  endtask

  task automatic test_wide();
    @(negedge clk);
    A8 = 8'hA5; B8 = 8'h3C; S8 = 1'b0; en8 = 1'b1;
    #1;
    checks++;
    if (Z8 !== 8'hA5) begin
      errors++;
      $display("FAIL wide_s0 got %h want a5", Z8);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Zq8 !== 8'hA5 || vld8 !== 1'b1) begin
      errors++;
      $display("FAIL wide_q0 got q=%h v=%b want q=a5 v=1", Zq8, vld8);
    end
    @(negedge clk);
    S8 = 1'b1;
    #1;
    checks++;
    if (Z8 !== 8'h3C) begin
      errors++;
      $display("FAIL wide_s1 got %h want 3c", Z8);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Zq8 !== 8'h3C) begin
      errors++;
      $display("FAIL wide_q1 got %h want 3c", Zq8);
    end
    exp8_q   = 8'h3C;
    exp8_vld = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] ez;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      A8  = 8'($urandom);
      B8  = 8'($urandom);
      S8  = 1'($urandom);
      en8 = ($urandom_range(3) != 0);
      ez  = ref_mux(A8, B8, S8);
      #1;
      checks++;
      if (Z8 !== ez) begin
        errors++;
        $display("FAIL rand_z[%0d] got %h want %h", i, Z8, ez);
      end
      if (i == 20) begin
        rst8 = 1'b1;
        exp8_q   = 8'h5A;
        exp8_vld = 1'b0;
        #1;
        checks++;
        if (Zq8 !== exp8_q || vld8 !== 1'b0) begin
          errors++;
          $display("FAIL rand_rst got q=%h v=%b want q=5a v=0", Zq8, vld8);
        end
        @(negedge clk);
        rst8 = 1'b0;
        ez = ref_mux(A8, B8, S8);
      end
      @(posedge clk);
      if (en8) begin
        exp8_q   = ez;
        exp8_vld = 1'b1;
      end
      #1;
      checks++;
      if (Zq8 !== exp8_q || vld8 !== exp8_vld) begin
        errors++;
        $display("FAIL rand_q[%0d] got q=%h v=%b want q=%h v=%b",
                 i, Zq8, vld8, exp8_q, exp8_vld);
      end
    end
  endtask

  task automatic test_x_select();
    @(negedge clk);
    en8 = 1'b0;
    A8 = 8'hFF; B8 = 8'hFF; S8 = 1'bx;
    #1;
    checks++;
    if (Z8 !== 8'hFF) begin
      errors++;
      $display("FAIL x_same got %h want ff", Z8);
    end
    A8 = 8'h00;
    #1;
    checks++;
    if ($isunknown(S8)) begin
      if (Z8 !== 8'hxx) begin
        errors++;
        $display("FAIL x_diff got %b want all x", Z8);
      end
    end else if (Z8 !== ref_mux(A8, B8, S8)) begin
      errors++;
      $display("FAIL x_diff_2state got %h want %h",
               Z8, ref_mux(A8, B8, S8));
    end
    S8 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst1 = 1'b0; rst8 = 1'b0;
    A1 = '0; B1 = '0; S1 = 1'b0; en1 = 1'b0;
    A8 = '0; B8 = '0; S8 = 1'b0; en8 = 1'b0;
    exp8_q = 8'h5A;
    exp8_vld = 1'b0;
    test_reset();
    test_truth();
    test_capture();
    test_hold();
    test_async_reset();
    test_wide();
    test_random();
    test_x_select();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
